// File: rtl/cpu_defs.sv
// Shared CPU types and the ALU reservation-station entry layout.
// The oldest-first select is enabled by ALU_RS_OLDEST_FIRST_EN (see rs_select / alu_rs).
package cpu_defs;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned ROB_TAG_MAX_W = 8;

  typedef logic [XLEN-1:0] uint32_t;
  typedef logic [XLEN-1:0] virt_t;

  typedef enum logic [3:0] {
    OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_LUI
  } oper_t;

  // Tags are stored at the widest supported ROB index; narrower tags zero-extend.
  typedef struct packed {
    logic                     valid;
    oper_t                    op;
    virt_t                    pc;
    uint32_t                  instr;
    logic [ROB_TAG_MAX_W-1:0] rob;
    logic                     rdy1;
    logic                     rdy2;
    uint32_t                  val1;
    uint32_t                  val2;
    logic [ROB_TAG_MAX_W-1:0] tag1;
    logic [ROB_TAG_MAX_W-1:0] tag2;
  } alu_rs_entry_t;

  function automatic logic cdb_hit(input logic rdy, input logic [ROB_TAG_MAX_W-1:0] tag,
                                   input logic cdb_v, input logic [ROB_TAG_MAX_W-1:0] cdb_t);
    return ~rdy & cdb_v & (tag == cdb_t);
  endfunction

  function automatic logic entry_ready(input alu_rs_entry_t e);
    return e.valid & e.rdy1 & e.rdy2;
  endfunction

endpackage

// File: rtl/rs_select.sv
// Reservation-station picker: ready vector -> one-hot grant.
// ALU_RS_OLDEST_FIRST_EN adds an age matrix (oldest ready wins); otherwise lowest index wins.
module rs_select #(
  parameter int unsigned DEPTH = 4
) (
`ifdef ALU_RS_OLDEST_FIRST_EN
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc,
`endif
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] gnt_c,
  output logic             any_c
);

`ifdef ALU_RS_OLDEST_FIRST_EN
  // older[i][j] set means entry i was dispatched before entry j
  logic [DEPTH-1:0] older [DEPTH];
  logic             blocked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc[k]) begin
          for (int j = 0; j < DEPTH; j++) begin
            older[k][j] <= 1'b0;
            if (j != k) older[j][k] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    gnt_c   = '0;
    blocked = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (req[j] && older[j][i]) blocked = 1'b1;
      end
      gnt_c[i] = req[i] & ~blocked;
    end
  end
`else
  logic found;

  always_comb begin
    gnt_c = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req[i] && !found) begin
        gnt_c[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

  assign any_c = |req;

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, wakes operands from the CDB and issues one
// ready op per cycle into a registered slot. ALU_RS_OLDEST_FIRST_EN selects oldest-first issue.
module alu_rs
  import cpu_defs::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dsp_valid,
  output logic             dsp_ready,
  input  oper_t            dsp_op,
  input  virt_t            dsp_pc,
  input  uint32_t          dsp_instr,
  input  logic [TAG_W-1:0] dsp_rob,
  input  logic             dsp_rdy1,
  input  logic             dsp_rdy2,
  input  uint32_t          dsp_val1,
  input  uint32_t          dsp_val2,
  input  logic [TAG_W-1:0] dsp_tag1,
  input  logic [TAG_W-1:0] dsp_tag2,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  uint32_t          cdb_data,
  output logic             iss_valid,
  input  logic             iss_ready,
  output oper_t            iss_op,
  output virt_t            iss_pc,
  output uint32_t          iss_instr,
  output uint32_t          iss_reg1,
  output uint32_t          iss_reg2,
  output logic [TAG_W-1:0] iss_rob
);

  localparam int unsigned TW = ROB_TAG_MAX_W;

  alu_rs_entry_t    ent_q [DEPTH];
  alu_rs_entry_t    ent_n [DEPTH];
  alu_rs_entry_t    dsp_ent;
  logic [DEPTH-1:0] req, gnt, free_oh, alloc, valid_n;
  logic             any_gnt, found_free, dsp_acc, advance, bypass;
  logic             slot_load, slot_valid_n, dsp_ready_n;
  oper_t            sel_op;
  virt_t            sel_pc;
  uint32_t          sel_instr, sel_reg1, sel_reg2;
  logic [TAG_W-1:0] sel_rob;

  // Ready vector and lowest free entry, both from registered state only
  always_comb begin
    req        = '0;
    free_oh    = '0;
    found_free = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      req[i] = entry_ready(ent_q[i]);
      if (!ent_q[i].valid && !found_free) begin
        free_oh[i] = 1'b1;
        found_free = 1'b1;
      end
    end
  end

  rs_select #(.DEPTH(DEPTH)) u_select (
`ifdef ALU_RS_OLDEST_FIRST_EN
    .clk   (clk),
    .rst   (rst),
    .alloc (alloc),
`endif
    .req   (req),
    .gnt_c (gnt),
    .any_c (any_gnt)
  );

  // Next entry/slot state; a fully-ready dispatch goes straight to an idle slot when nothing stored is ready
  always_comb begin
    dsp_ent       = '0;
    dsp_ent.valid = 1'b1;
    dsp_ent.op    = dsp_op;
    dsp_ent.pc    = dsp_pc;
    dsp_ent.instr = dsp_instr;
    dsp_ent.rob   = TW'(dsp_rob);
    dsp_ent.tag1  = TW'(dsp_tag1);
    dsp_ent.tag2  = TW'(dsp_tag2);
    dsp_ent.rdy1  = dsp_rdy1 | cdb_hit(dsp_rdy1, TW'(dsp_tag1), cdb_valid, TW'(cdb_tag));
    dsp_ent.rdy2  = dsp_rdy2 | cdb_hit(dsp_rdy2, TW'(dsp_tag2), cdb_valid, TW'(cdb_tag));
    dsp_ent.val1  = dsp_rdy1 ? dsp_val1 : cdb_data;
    dsp_ent.val2  = dsp_rdy2 ? dsp_val2 : cdb_data;

    dsp_acc      = dsp_valid & dsp_ready;
    advance      = ~iss_valid | iss_ready;
    bypass       = advance & ~any_gnt & dsp_acc & dsp_ent.rdy1 & dsp_ent.rdy2;
    alloc        = (dsp_acc && !bypass) ? free_oh : '0;
    slot_load    = advance;
    slot_valid_n = any_gnt | bypass;

    sel_op    = OP_ADDU;
    sel_pc    = '0;
    sel_instr = '0;
    sel_reg1  = '0;
    sel_reg2  = '0;
    sel_rob   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (gnt[i]) begin
        sel_op    = ent_q[i].op;
        sel_pc    = ent_q[i].pc;
        sel_instr = ent_q[i].instr;
        sel_reg1  = ent_q[i].val1;
        sel_reg2  = ent_q[i].val2;
        sel_rob   = TAG_W'(ent_q[i].rob);
      end
    end
    if (bypass) begin
      sel_op    = dsp_ent.op;
      sel_pc    = dsp_ent.pc;
      sel_instr = dsp_ent.instr;
      sel_reg1  = dsp_ent.val1;
      sel_reg2  = dsp_ent.val2;
      sel_rob   = dsp_rob;
    end

    for (int i = 0; i < DEPTH; i++) begin
      ent_n[i] = ent_q[i];
      if (ent_q[i].valid && cdb_hit(ent_q[i].rdy1, ent_q[i].tag1, cdb_valid, TW'(cdb_tag))) begin
        ent_n[i].rdy1 = 1'b1;
        ent_n[i].val1 = cdb_data;
      end
      if (ent_q[i].valid && cdb_hit(ent_q[i].rdy2, ent_q[i].tag2, cdb_valid, TW'(cdb_tag))) begin
        ent_n[i].rdy2 = 1'b1;
        ent_n[i].val2 = cdb_data;
      end
      if (advance && gnt[i]) ent_n[i].valid = 1'b0;
      if (alloc[i]) ent_n[i] = dsp_ent;
    end

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_n[i].valid = 1'b0;
      alloc        = '0;
      slot_load    = 1'b1;
      slot_valid_n = 1'b0;
    end

    for (int i = 0; i < DEPTH; i++) valid_n[i] = ent_n[i].valid;
    dsp_ready_n = ~&valid_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      dsp_ready <= 1'b1;
      iss_valid <= 1'b0;
      iss_op    <= OP_ADDU;
      iss_pc    <= '0;
      iss_instr <= '0;
      iss_reg1  <= '0;
      iss_reg2  <= '0;
      iss_rob   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_n[i];
      dsp_ready <= dsp_ready_n;
      if (slot_load) iss_valid <= slot_valid_n;
      if (slot_load && slot_valid_n) begin
        iss_op    <= sel_op;
        iss_pc    <= sel_pc;
        iss_instr <= sel_instr;
        iss_reg1  <= sel_reg1;
        iss_reg2  <= sel_reg2;
        iss_rob   <= sel_rob;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios with literal expectations plus a random run against a
// behavioural model. Expectations follow ALU_RS_OLDEST_FIRST_EN when it is defined.
module tb_alu_rs;
  import cpu_defs::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             dsp_valid = 1'b0;
  logic             dsp_ready;
  oper_t            dsp_op = OP_ADDU;
  virt_t            dsp_pc = '0;
  uint32_t          dsp_instr = '0;
  logic [TAG_W-1:0] dsp_rob = '0;
  logic             dsp_rdy1 = 1'b0, dsp_rdy2 = 1'b0;
  uint32_t          dsp_val1 = '0, dsp_val2 = '0;
  logic [TAG_W-1:0] dsp_tag1 = '0, dsp_tag2 = '0;
  logic             cdb_valid = 1'b0;
  logic [TAG_W-1:0] cdb_tag = '0;
  uint32_t          cdb_data = '0;
  logic             iss_valid;
  logic             iss_ready = 1'b0;
  oper_t            iss_op;
  virt_t            iss_pc;
  uint32_t          iss_instr, iss_reg1, iss_reg2;
  logic [TAG_W-1:0] iss_rob;

  alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dsp_valid(dsp_valid), .dsp_ready(dsp_ready), .dsp_op(dsp_op), .dsp_pc(dsp_pc),
    .dsp_instr(dsp_instr), .dsp_rob(dsp_rob), .dsp_rdy1(dsp_rdy1), .dsp_rdy2(dsp_rdy2),
    .dsp_val1(dsp_val1), .dsp_val2(dsp_val2), .dsp_tag1(dsp_tag1), .dsp_tag2(dsp_tag2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_pc(iss_pc),
    .iss_instr(iss_instr), .iss_reg1(iss_reg1), .iss_reg2(iss_reg2), .iss_rob(iss_rob)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: a bag of waiting ops with dispatch sequence numbers, plus the issue slot
  bit          m_v  [DEPTH];
  bit          m_r1 [DEPTH];
  bit          m_r2 [DEPTH];
  logic [31:0] m_val1 [DEPTH], m_val2 [DEPTH], m_pc [DEPTH], m_instr [DEPTH];
  int          m_tag1 [DEPTH], m_tag2 [DEPTH], m_rob [DEPTH], m_op [DEPTH];
  longint      m_seq [DEPTH];
  longint      seq_ctr = 0;
  bit          s_v = 1'b0;
  int          s_op = 0, s_rob = 0;
  logic [31:0] s_pc, s_instr, s_r1, s_r2;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_v[i]);
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int pick, fr;
    bit adv, acc, store, nr1, nr2;
    logic [31:0] nv1, nv2;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
      s_v = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
      s_v = 1'b0;
    end else begin
      pick = -1;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_v[i] && m_r1[i] && m_r2[i]) begin
`ifdef ALU_RS_OLDEST_FIRST_EN
          if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
          if (pick < 0) pick = i;
`endif
        end
      end
      fr = -1;
      for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) fr = i;
      adv   = !s_v || iss_ready;
      acc   = dsp_valid && (m_count() < DEPTH);
      store = acc;
      nr1 = dsp_rdy1 || (cdb_valid && dsp_tag1 == cdb_tag);
      nr2 = dsp_rdy2 || (cdb_valid && dsp_tag2 == cdb_tag);
      nv1 = dsp_rdy1 ? dsp_val1 : cdb_data;
      nv2 = dsp_rdy2 ? dsp_val2 : cdb_data;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_v[i] && cdb_valid && !m_r1[i] && m_tag1[i] == int'(cdb_tag)) begin
          m_r1[i] = 1'b1; m_val1[i] = cdb_data;
        end
        if (m_v[i] && cdb_valid && !m_r2[i] && m_tag2[i] == int'(cdb_tag)) begin
          m_r2[i] = 1'b1; m_val2[i] = cdb_data;
        end
      end
      if (adv) begin
        if (pick >= 0) begin
          s_v = 1'b1; s_op = m_op[pick]; s_rob = m_rob[pick]; s_pc = m_pc[pick];
          s_instr = m_instr[pick]; s_r1 = m_val1[pick]; s_r2 = m_val2[pick];
          m_v[pick] = 1'b0;
        end else if (acc && nr1 && nr2) begin
          s_v = 1'b1; s_op = int'(dsp_op); s_rob = int'(dsp_rob); s_pc = dsp_pc;
          s_instr = dsp_instr; s_r1 = nv1; s_r2 = nv2;
          store = 1'b0;
        end else begin
          s_v = 1'b0;
        end
      end
      if (store) begin
        m_v[fr] = 1'b1; m_r1[fr] = nr1; m_r2[fr] = nr2; m_val1[fr] = nv1; m_val2[fr] = nv2;
        m_tag1[fr] = int'(dsp_tag1); m_tag2[fr] = int'(dsp_tag2); m_rob[fr] = int'(dsp_rob);
        m_op[fr] = int'(dsp_op); m_pc[fr] = dsp_pc; m_instr[fr] = dsp_instr;
        m_seq[fr] = seq_ctr; seq_ctr++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("iss_valid", 64'(iss_valid), 64'(s_v));
      chk("dsp_ready", 64'(dsp_ready), 64'(m_count() < DEPTH));
      if (s_v) begin
        chk("iss_regs", 64'({iss_reg1, iss_reg2}), 64'({s_r1, s_r2}));
        chk("iss_ctl", 64'({iss_op, iss_rob, iss_pc}), 64'({4'(s_op), 4'(s_rob), s_pc}));
        chk("iss_instr", 64'(iss_instr), 64'(s_instr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input int op, input int rob, input bit r1, input logic [31:0] v1,
                      input int t1, input bit r2, input logic [31:0] v2, input int t2);
    dsp_valid = 1'b1;
    dsp_op    = oper_t'(4'(op));
    dsp_rob   = TAG_W'(rob);
    dsp_pc    = 32'h1000 + 32'(rob * 4);
    dsp_instr = 32'h0000_0013 | (32'(rob) << 20);
    dsp_rdy1  = r1; dsp_val1 = v1; dsp_tag1 = TAG_W'(t1);
    dsp_rdy2  = r2; dsp_val2 = v2; dsp_tag2 = TAG_W'(t2);
  endtask

  initial begin
    int exp_rob;
    tick(); tick();
    rst = 1'b0;
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_dsp_ready", 64'(dsp_ready), 64'd1);
    chk("rst_iss_data", 64'({iss_reg1, iss_reg2}), 64'd0);
    chk("rst_iss_rob_pc", 64'({iss_rob, iss_pc}), 64'd0);

    // 1: both ready, one cycle to the slot
    iss_ready = 1'b1;
    disp(0, 1, 1, 32'd5, 0, 1, 32'd7, 0);
    tick(); dsp_valid = 1'b0;
    chk("t1_valid", 64'(iss_valid), 64'd1);
    chk("t1_regs", 64'({iss_reg1, iss_reg2}), {32'd5, 32'd7});
    tick();
    chk("t1_drain", 64'(iss_valid), 64'd0);

    // 2: wakeup at t -> slot at t+2
    disp(0, 2, 0, 32'd0, 3, 1, 32'd1, 0);
    tick(); dsp_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'hDEAD;
    tick(); cdb_valid = 1'b0;
    chk("t2_t1", 64'(iss_valid), 64'd0);
    tick();
    chk("t2_t2", 64'(iss_valid), 64'd1);
    chk("t2_reg1", 64'(iss_reg1), 64'h0000_DEAD);
    tick();

    // 3: dispatch and matching broadcast in the same cycle
    disp(1, 3, 1, 32'h11, 0, 0, 32'd0, 9);
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'h1234;
    tick(); dsp_valid = 1'b0; cdb_valid = 1'b0;
    chk("t3_valid", 64'(iss_valid), 64'd1);
    chk("t3_reg2", 64'(iss_reg2), 64'h1234);
    tick();

    // 4: fill while stalled, then drain one per cycle
    iss_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      disp(2, k, 1, 32'(k), 0, 1, 32'(2 * k), 0);
      tick();
    end
    dsp_valid = 1'b0;
    chk("t4_full", 64'(dsp_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_hold", 64'({iss_valid, iss_rob, iss_reg1}), {59'd1, 1'b1, 4'd1} << 0 == 64'd0 ? 64'd0 : 64'({1'b1, 4'd1, 32'd1}));
    end
    iss_ready = 1'b1;
    tick();
    chk("t4_first", 64'(iss_rob), 64'd2);
    chk("t4_ready", 64'(dsp_ready), 64'd1);
    for (int k = 3; k <= 5; k++) begin
      tick();
      chk("t4_order", 64'(iss_rob), 64'(k));
    end
    tick();
    chk("t4_empty", 64'(iss_valid), 64'd0);

    // 5: older entry at idx2 versus younger at idx0
    iss_ready = 1'b0;
    disp(0, 1, 1, 32'd1, 0, 1, 32'd1, 0); tick();
    disp(0, 2, 1, 32'd2, 0, 1, 32'd2, 0); tick();
    disp(0, 3, 0, 32'd0, 6, 1, 32'd3, 0); tick();
    disp(0, 10, 0, 32'd0, 7, 1, 32'd4, 0); tick();
    dsp_valid = 1'b0; iss_ready = 1'b1; tick();
    iss_ready = 1'b0;
    chk("t5_p", 64'(iss_rob), 64'd2);
    disp(0, 11, 1, 32'd5, 0, 1, 32'd6, 0);
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 32'h77;
    tick(); dsp_valid = 1'b0; cdb_valid = 1'b0;
    tick();
    iss_ready = 1'b1; tick(); iss_ready = 1'b0;
`ifdef ALU_RS_OLDEST_FIRST_EN
    exp_rob = 10;
`else
    exp_rob = 11;
`endif
    chk("t5_pick", 64'(iss_rob), 64'(exp_rob));

    // 6: flush with three entries and a full slot, then async reset mid-stream
    disp(0, 12, 0, 32'd0, 8, 1, 32'd0, 0); tick();
    flush = 1'b1;
    disp(0, 13, 1, 32'd9, 0, 1, 32'd9, 0);
    tick(); flush = 1'b0; dsp_valid = 1'b0;
    chk("t6_flush_valid", 64'(iss_valid), 64'd0);
    chk("t6_flush_ready", 64'(dsp_ready), 64'd1);
    iss_ready = 1'b1; tick(); tick();
    chk("t6_quiet", 64'(iss_valid), 64'd0);
    iss_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      disp(3, k, 1, 32'(k), 0, 1, 32'(k), 0); tick();
    end
    dsp_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst", 64'({iss_valid, dsp_ready, iss_rob, iss_reg1}), 64'({1'b0, 1'b1, 4'd0, 32'd0}));
    tick(); rst = 1'b0;

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      dsp_valid = ($urandom_range(0, 9) < 6);
      dsp_op    = oper_t'(4'($urandom_range(0, 11)));
      dsp_rob   = TAG_W'($urandom_range(0, 15));
      dsp_pc    = $urandom; dsp_instr = $urandom;
      dsp_rdy1  = 1'($urandom_range(0, 1)); dsp_val1 = $urandom;
      dsp_rdy2  = 1'($urandom_range(0, 1)); dsp_val2 = $urandom;
      dsp_tag1  = TAG_W'($urandom_range(0, 3));
      dsp_tag2  = TAG_W'($urandom_range(0, 3));
      cdb_valid = 1'($urandom_range(0, 1));
      cdb_tag   = TAG_W'($urandom_range(0, 3));
      cdb_data  = $urandom;
      iss_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 99) == 0);
      tick();
    end
    dsp_valid = 1'b0; flush = 1'b0; cdb_valid = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
